sdram_rd32_responder: RTL and testbench

SDRAM_RD32_RESPONDER -- requirements
Module: sdram_rd32_responder

---
 rtl/sdram_rd32_responder.sv | 135 +++++++++++++
 tb/tb_sdram_rd32_responder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_rd32_responder.sv
// rtl/sdram_rd32_responder.sv - turns 32-bit read requests into 2-beat 16-bit SDRAM bursts
// One-entry pending buffer in front of a burst FSM with a per-beat timeout.
module sdram_rd32_responder #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [24:0] sdr_addr,
    input  logic        sdr_req,
    output logic [31:0] sdr_data,
    output logic        sdr_rdy,
    output logic [24:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [15:0] mem_dout,
    input  logic        mem_dvalid,
    output logic        err_timeout,
    output logic        err_overflow
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, DONE} state_t;

    localparam logic [9:0] TMO = 10'(TIMEOUT);

    state_t      state_q, state_d;
    logic        buf_valid_q, buf_valid_d;
    logic [24:0] buf_addr_q, buf_addr_d;
    logic [9:0]  timer_q, timer_d;
    logic [9:0]  timer_inc;
    logic        mem_rd_q, mem_rd_d;
    logic [24:0] mem_addr_q, mem_addr_d;
    logic        sdr_rdy_q, sdr_rdy_d;
    logic [31:0] sdr_data_q, sdr_data_d;
    logic        err_timeout_q, err_timeout_d;
    logic        err_overflow_q, err_overflow_d;
    logic        consume;

    always_comb begin
        state_d        = state_q;
        buf_valid_d    = buf_valid_q;
        buf_addr_d     = buf_addr_q;
        timer_d        = timer_q;
        mem_rd_d       = mem_rd_q;
        mem_addr_d     = mem_addr_q;
        sdr_rdy_d      = 1'b0;
        sdr_data_d     = sdr_data_q;
        err_timeout_d  = err_timeout_q;
        err_overflow_d = err_overflow_q;
        timer_inc      = timer_q + 10'd1;
        consume        = (state_q == IDLE) && buf_valid_q;

        // A slot freed by IDLE this cycle may be refilled by a same-cycle request.
        if (sdr_req) begin
            if (!buf_valid_q || consume) begin
                buf_valid_d = 1'b1;
                buf_addr_d  = sdr_addr;
            end else begin
                err_overflow_d = 1'b1;
            end
        end else if (consume) begin
            buf_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (buf_valid_q) begin
                    mem_addr_d = {buf_addr_q[24:2], 2'b00};
                    mem_rd_d   = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    mem_rd_d = 1'b0;
                    timer_d  = 10'd0;
                    state_d  = WAIT_LO;
                end
            end
            WAIT_LO, WAIT_HI: begin
                if (mem_dvalid) begin
                    timer_d = 10'd0;
                    if (state_q == WAIT_LO) begin
                        sdr_data_d[15:0] = mem_dout;
                        state_d          = WAIT_HI;
                    end else begin
                        sdr_data_d[31:16] = mem_dout;
                        sdr_rdy_d         = 1'b1;
                        state_d           = DONE;
                    end
                end else if (timer_inc == TMO) begin
                    sdr_data_d    = '1;
                    err_timeout_d = 1'b1;
                    sdr_rdy_d     = 1'b1;
                    state_d       = DONE;
                end else begin
                    timer_d = timer_inc;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            buf_valid_q    <= 1'b0;
            buf_addr_q     <= '0;
            timer_q        <= '0;
            mem_rd_q       <= 1'b0;
            mem_addr_q     <= '0;
            sdr_rdy_q      <= 1'b0;
            sdr_data_q     <= '0;
            err_timeout_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            buf_valid_q    <= buf_valid_d;
            buf_addr_q     <= buf_addr_d;
            timer_q        <= timer_d;
            mem_rd_q       <= mem_rd_d;
            mem_addr_q     <= mem_addr_d;
            sdr_rdy_q      <= sdr_rdy_d;
            sdr_data_q     <= sdr_data_d;
            err_timeout_q  <= err_timeout_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign sdr_data     = sdr_data_q;
    assign sdr_rdy      = sdr_rdy_q;
    assign mem_addr     = mem_addr_q;
    assign mem_rd       = mem_rd_q;
    assign err_timeout  = err_timeout_q;
    assign err_overflow = err_overflow_q;
endmodule

// File: tb/tb_sdram_rd32_responder.sv
// tb/tb_sdram_rd32_responder.sv - directed and random bench for sdram_rd32_responder
module tb_sdram_rd32_responder;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [24:0] sdr_addr;
    logic        sdr_req;
    logic [31:0] sdr_data;
    logic        sdr_rdy;
    logic [24:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack;
    logic [15:0] mem_dout;
    logic        mem_dvalid;
    logic        err_timeout;
    logic        err_overflow;

    int vectors = 0;
    int misc    = 0;
    int rdy_count = 0;

    sdram_rd32_responder #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .sdr_addr(sdr_addr), .sdr_req(sdr_req),
        .sdr_data(sdr_data), .sdr_rdy(sdr_rdy), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_ack(mem_ack), .mem_dout(mem_dout), .mem_dvalid(mem_dvalid),
        .err_timeout(err_timeout), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    // Transaction-level reference: pending slot, one request in flight, beat count and idle-time counter.
    typedef struct packed {
        logic        pv;
        logic [24:0] pa;
        logic        busy;
        logic        acked;
        logic        hi;
        logic [9:0]  wait_c;
        logic [31:0] data;
        logic        rdy;
        logic        rd;
        logic [24:0] maddr;
        logic        eto;
        logic        eov;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_step(input mstate_t s, input logic req, input logic [24:0] addr,
                                           input logic ack, input logic dv, input logic [15:0] dout);
        mstate_t n = s;
        if (req) begin
            if (!s.pv || !s.busy) begin
                n.pv = 1'b1;
                n.pa = addr;
            end else begin
                n.eov = 1'b1;
            end
        end else if (s.pv && !s.busy) begin
            n.pv = 1'b0;
        end
        if (s.rdy) begin
            n.rdy  = 1'b0;
            n.busy = 1'b0;
        end else if (!s.busy) begin
            if (s.pv) begin
                n.busy  = 1'b1;
                n.acked = 1'b0;
                n.rd    = 1'b1;
                n.maddr = s.pa & ~25'd3;
            end
        end else if (!s.acked) begin
            if (ack) begin
                n.acked  = 1'b1;
                n.rd     = 1'b0;
                n.hi     = 1'b0;
                n.wait_c = 10'd0;
            end
        end else if (dv) begin
            n.wait_c = 10'd0;
            if (!s.hi) begin
                n.data[15:0] = dout;
                n.hi = 1'b1;
            end else begin
                n.data[31:16] = dout;
                n.rdy = 1'b1;
            end
        end else if (int'(s.wait_c) + 1 == TMO) begin
            n.data = 32'hFFFF_FFFF;
            n.eto  = 1'b1;
            n.rdy  = 1'b1;
        end else begin
            n.wait_c = s.wait_c + 10'd1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= '0;
        else          m <= model_step(m, sdr_req, sdr_addr, mem_ack, mem_dvalid, mem_dout);
    end

    always @(posedge clk) begin
        if (reset_n && sdr_rdy) rdy_count <= rdy_count + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (reset_n) begin
            chk("sdr_data", sdr_data, m.data);
            chk("sdr_rdy", 32'(sdr_rdy), 32'(m.rdy));
            chk("mem_rd", 32'(mem_rd), 32'(m.rd));
            chk("mem_addr", 32'(mem_addr), 32'(m.maddr));
            chk("err_timeout", 32'(err_timeout), 32'(m.eto));
            chk("err_overflow", 32'(err_overflow), 32'(m.eov));
        end
        sdr_req    = 1'b0;
        mem_ack    = 1'b0;
        mem_dvalid = 1'b0;
    endtask

    task automatic request(input logic [24:0] a);
        sdr_req  = 1'b1;
        sdr_addr = a;
        tick();
    endtask

    // Waits (bounded) for mem_rd, then acks after ackd cycles and sends two beats with gaps.
    task automatic serve(input int ackd, input int g1, input int g2, input logic [15:0] lo, input logic [15:0] hi);
        int n = 0;
        while (!mem_rd && n < 50) begin
            tick();
            n++;
        end
        chk("mem_rd_wait", 32'(mem_rd), 32'd1);
        if (!mem_rd) return;
        repeat (ackd) tick();
        mem_ack = 1'b1;
        tick();
        repeat (g1) tick();
        mem_dvalid = 1'b1;
        mem_dout   = lo;
        tick();
        repeat (g2) tick();
        mem_dvalid = 1'b1;
        mem_dout   = hi;
        tick();
    endtask

    initial begin
        int base;
        int n;
        int ag_phase;
        int ag_cnt;
        int ag_beats;
        reset_n = 1'b0;
        sdr_addr = '0; sdr_req = 1'b0; mem_ack = 1'b0; mem_dout = '0; mem_dvalid = 1'b0;
        #3;
        chk("reset_outputs", {sdr_data[30:0] | {6'd0, mem_addr}, sdr_rdy}, 32'd0);
        chk("reset_flags", {29'd0, mem_rd, err_timeout, err_overflow}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // basic read
        request(25'h0012347);
        tick();
        chk("basic_mem_rd", 32'(mem_rd), 32'd1);
        chk("basic_mem_addr", 32'(mem_addr), 32'h0012344);
        serve(3, 0, 0, 16'hBEEF, 16'hDEAD);
        chk("basic_rdy", 32'(sdr_rdy), 32'd1);
        chk("basic_data", sdr_data, 32'hDEADBEEF);
        tick();
        chk("basic_rdy_one_cycle", 32'(sdr_rdy), 32'd0);

        // back-to-back: second request lands on the cycle IDLE consumes the first
        base = rdy_count;
        request(25'h0000100);
        request(25'h0000206);
        serve(1, 1, 0, 16'h1111, 16'h2222);
        chk("b2b_first_data", sdr_data, 32'h22221111);
        serve(0, 0, 2, 16'h3333, 16'h4444);
        tick();
        chk("b2b_second_addr", 32'(mem_addr), 32'h0000204);
        chk("b2b_rdy_count", 32'(rdy_count - base), 32'd2);
        chk("b2b_no_overflow", 32'(err_overflow), 32'd0);

        // simultaneous refill after a completed burst
        base = rdy_count;
        request(25'h0000300);
        tick();
        request(25'h0000400);
        serve(0, 0, 0, 16'hAAAA, 16'hBBBB);
        tick();
        request(25'h0000500);
        serve(0, 0, 0, 16'hCCCC, 16'hDDDD);
        serve(0, 0, 0, 16'hEEEE, 16'hFFFF);
        tick();
        chk("simul_rdy_count", 32'(rdy_count - base), 32'd3);
        chk("simul_no_overflow", 32'(err_overflow), 32'd0);

        // overflow: third request dropped while first awaits ack
        base = rdy_count;
        request(25'h0000600);
        tick();
        tick();
        request(25'h0000700);
        request(25'h0000800);
        chk("ovf_flag", 32'(err_overflow), 32'd1);
        serve(2, 0, 0, 16'h0101, 16'h0202);
        serve(0, 0, 0, 16'h0303, 16'h0404);
        repeat (10) tick();
        chk("ovf_rdy_count", 32'(rdy_count - base), 32'd2);
        chk("ovf_kept_addr", 32'(mem_addr), 32'h0000700);

        // timeout: no beats after ack
        request(25'h0000900);
        tick();
        mem_ack = 1'b1;
        tick();
        n = 0;
        while (!sdr_rdy && n < 40) begin
            tick();
            n++;
        end
        chk("tmo_latency", 32'(n), 32'd8);
        chk("tmo_data", sdr_data, 32'hFFFFFFFF);
        chk("tmo_flag", 32'(err_timeout), 32'd1);
        tick();

        // reset while in WAIT_HI
        request(25'h0000A00);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_dvalid = 1'b1;
        mem_dout   = 16'h5555;
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_data", sdr_data, 32'd0);
        chk("rst_ctrl", {26'd0, sdr_rdy, mem_rd, err_timeout, err_overflow, 2'd0}, 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        tick();
        reset_n = 1'b1;
        base = rdy_count;
        mem_dvalid = 1'b1;
        mem_dout   = 16'h6666;
        tick();
        repeat (5) tick();
        chk("rst_late_beat_ignored", 32'(rdy_count - base), 32'd0);
        chk("rst_data_held", sdr_data, 32'd0);
        request(25'h0000B01);
        serve(1, 0, 1, 16'h7777, 16'h8888);
        chk("rst_fresh_data", sdr_data, 32'h88887777);
        chk("rst_fresh_rdy", 32'(sdr_rdy), 32'd1);

        // random traffic against the model
        ag_phase = 0; ag_cnt = 0; ag_beats = 0;
        for (int i = 0; i < 3300; i++) begin
            tick();
            if (i < 3000 && $urandom_range(0, 5) == 0) begin
                sdr_req  = 1'b1;
                sdr_addr = 25'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                mem_dvalid = 1'b1;
                mem_dout   = 16'($urandom);
                if (ag_phase == 2) mem_dvalid = 1'b0;
            end
            case (ag_phase)
                0: if (mem_rd) begin ag_cnt = $urandom_range(0, 4); ag_phase = 1; end
                1: if (ag_cnt == 0) begin mem_ack = 1'b1; ag_beats = 0; ag_cnt = $urandom_range(0, 10); ag_phase = 2; end
                   else ag_cnt--;
                default: if (ag_cnt == 0) begin
                        mem_dvalid = 1'b1;
                        mem_dout   = 16'($urandom);
                        ag_beats++;
                        ag_cnt = $urandom_range(0, 10);
                        if (ag_beats == 2) ag_phase = 0;
                    end else ag_cnt--;
            endcase
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end
endmodule
